mux_rr_scheduler: RTL and testbench

Four-channel ingress buffer and round-robin scheduler that feeds the team's registered 4:1, 4-bit output multiplexer. It captures one word per channel behind a valid/ready handshake and drives the multiplexer's four data inputs and `sel`. It flags the multiplexer's registered output as valid with a downstream valid/ready handshake, so words are delivered one at a time in fair order.

---
 rtl/mux_rr_scheduler.sv | 151 +++++++++++++++
 tb/tb_mux_rr_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler
//   Four-channel ingress buffer plus scheduler that drives an external
//   registered 4:1 multiplexer. Each channel holds one word behind a
//   valid/ready handshake. Granted words are presented one at a time through
//   the multiplexer with a downstream valid/ready handshake.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid[3:0]          per-channel word offered
//   req_ready[3:0]          per-channel buffer empty (combinational)
//   req_data0..3 [DW-1:0]   channel words
//   hold0..3     [DW-1:0]   holding registers -> multiplexer input1..input4
//   sel[1:0]                registered channel select -> multiplexer sel
//   out_valid               multiplexer out carries the granted word
//   out_ready               downstream accepts the presented word
//
// Build option
//   MUX_RR_FIXED_PRIO_EN    fixed priority (ch0 highest) instead of round-robin
module mux_rr_scheduler #(
  parameter int unsigned DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req_valid,
  output logic [3:0]    req_ready,
  input  logic [DW-1:0] req_data0,
  input  logic [DW-1:0] req_data1,
  input  logic [DW-1:0] req_data2,
  input  logic [DW-1:0] req_data3,
  output logic [DW-1:0] hold0,
  output logic [DW-1:0] hold1,
  output logic [DW-1:0] hold2,
  output logic [DW-1:0] hold3,
  output logic [1:0]    sel,
  output logic          out_valid,
  input  logic          out_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    full_q, full_d;
  logic [DW-1:0] hold_q [4];
  logic [DW-1:0] hold_d [4];
  logic [DW-1:0] req_data [4];
  logic [1:0]    sel_q, sel_d;
  logic          out_valid_q, out_valid_d;
  logic [1:0]    grant;
`ifndef MUX_RR_FIXED_PRIO_EN
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    idx;
`endif

  assign req_data[0] = req_data0;
  assign req_data[1] = req_data1;
  assign req_data[2] = req_data2;
  assign req_data[3] = req_data3;

  assign req_ready = ~full_q;
  assign hold0     = hold_q[0];
  assign hold1     = hold_q[1];
  assign hold2     = hold_q[2];
  assign hold3     = hold_q[3];
  assign sel       = sel_q;
  assign out_valid = out_valid_q;

  // Arbitration: scan from lowest to highest priority, last hit wins.
  always_comb begin
    grant = '0;
`ifdef MUX_RR_FIXED_PRIO_EN
    for (int unsigned i = 4; i > 0; i--) begin
      if (full_q[2'(i - 1)]) grant = 2'(i - 1);
    end
`else
    idx = '0;
    // k = 1 (ptr+1) is the highest priority, k = 4 (ptr itself) the lowest.
    for (int unsigned k = 4; k > 0; k--) begin
      idx = ptr_q + 2'(k);
      if (full_q[idx]) grant = idx;
    end
`endif
  end

  // State register and all flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      full_q      <= '0;
      sel_q       <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) hold_q[i] <= '0;
`ifndef MUX_RR_FIXED_PRIO_EN
      ptr_q       <= 2'd3;
`endif
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      for (int unsigned i = 0; i < 4; i++) hold_q[i] <= hold_d[i];
`ifndef MUX_RR_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
`ifndef MUX_RR_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|full_q) begin
          state_d = SETTLE;
          sel_d   = grant;
`ifndef MUX_RR_FIXED_PRIO_EN
          ptr_d   = grant;
`endif
        end
      end
      SETTLE:  state_d = PRESENT;
      PRESENT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Buffer and output logic. The granted channel is full throughout SETTLE and
  // PRESENT, so an accept and a handshake release can never hit the same bit.
  always_comb begin
    full_d = full_q;
    for (int unsigned i = 0; i < 4; i++) begin
      hold_d[i] = hold_q[i];
      if (req_valid[i] && !full_q[i]) begin
        full_d[i] = 1'b1;
        hold_d[i] = req_data[i];
      end
    end
    if (state_q == PRESENT && out_ready) full_d[sel_q] = 1'b0;
    // out_valid is exactly "next state is PRESENT": set leaving SETTLE,
    // cleared on the handshake that returns to IDLE.
    out_valid_d = (state_d == PRESENT);
  end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
module tb_mux_rr_scheduler;
  localparam int unsigned DW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req_valid = '0;
  logic [3:0]    req_ready;
  logic [DW-1:0] rd [4];
  logic [DW-1:0] hold0, hold1, hold2, hold3;
  logic [1:0]    sel;
  logic          out_valid;
  logic          out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  mux_rr_scheduler #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data0(rd[0]), .req_data1(rd[1]), .req_data2(rd[2]), .req_data3(rd[3]),
    .hold0(hold0), .hold1(hold1), .hold2(hold2), .hold3(hold3),
    .sel(sel), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // External registered 4:1 multiplexer.
  logic [DW-1:0] hold_v [4];
  logic [DW-1:0] mux_out;
  assign hold_v[0] = hold0;
  assign hold_v[1] = hold1;
  assign hold_v[2] = hold2;
  assign hold_v[3] = hold3;
  initial forever begin
    @(posedge clk);
    mux_out <= hold_v[sel];
  end

  // Transaction-level reference: per-channel buffers, last winner, and the
  // number of edges since the current grant took effect.
  logic [3:0]    m_full;
  logic [DW-1:0] m_data [4];
  logic [1:0]    m_sel;
  int            m_last, m_cur, m_age, m_base, m_c;
  logic [3:0]    m_acc;
  initial begin
    m_full = '0; m_last = 3; m_cur = -1; m_age = 0; m_sel = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_full = '0; m_last = 3; m_cur = -1; m_age = 0; m_sel = '0;
      end else begin
        m_acc = req_valid & ~m_full;
        if (m_cur < 0) begin
          if (m_full != 4'b0) begin
`ifdef MUX_RR_FIXED_PRIO_EN
            m_base = -1;
`else
            m_base = m_last;
`endif
            for (int k = 1; k <= 4; k++) begin
              m_c = (m_base + k) % 4;
              if (m_full[m_c] && m_cur < 0) m_cur = m_c;
            end
            m_last = m_cur;
            m_sel  = 2'(m_cur);
            m_age  = 0;
          end
        end else if (m_age >= 1 && out_ready) begin
          m_full[m_cur] = 1'b0;
          m_cur = -1;
        end else begin
          m_age = m_age + 1;
        end
        for (int i = 0; i < 4; i++) begin
          if (m_acc[i]) begin
            m_full[i] = 1'b1;
            m_data[i] = rd[i];
          end
        end
      end
    end
  end

  task automatic apply_reset;
    req_valid = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) rd[i] = '0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b1111) begin errors++; $display("FAIL reset_req_ready got=%b exp=1111", req_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({hold3, hold2, hold1, hold0} !== '0) begin
      errors++; $display("FAIL reset_holds got=%h exp=0", {hold3, hold2, hold1, hold0});
    end
  endtask

  task automatic test_single_word;
    apply_reset();
    out_ready = 1'b1;
    req_valid = 4'b0100; rd[2] = 4'hA;
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (req_ready[2] !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL single_accept req_ready=%b out_valid=%b exp 0/0", req_ready, out_valid);
    end
    @(negedge clk);
    checks++;
    if (sel !== 2'b10 || out_valid !== 1'b0) begin
      errors++; $display("FAIL single_sel sel=%0d out_valid=%b exp 2/0", sel, out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || mux_out !== 4'hA) begin
      errors++; $display("FAIL single_present out_valid=%b out=%h exp 1/a", out_valid, mux_out);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || req_ready[2] !== 1'b1) begin
      errors++; $display("FAIL single_release out_valid=%b req_ready=%b exp 0/x1xx", out_valid, req_ready);
    end
  endtask

  task automatic test_round_robin;
    logic [DW-1:0] got [6];
    logic [1:0]    gsel [6];
    int            at [6];
    int            n;
    logic [DW-1:0] r0, r3;
    apply_reset();
    out_ready = 1'b1;
    req_valid = 4'b1111;
    rd[0] = 4'd1; rd[1] = 4'd2; rd[2] = 4'd3; rd[3] = 4'd4;
    @(negedge clk);
    req_valid = '0;
    n = 0;
    for (int c = 0; c < 16 && n < 4; c++) begin
      if (out_valid) begin got[n] = mux_out; gsel[n] = sel; at[n] = c; n++; end
      if (n < 4) @(negedge clk);
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL rr_count got=%0d exp=4", n); end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got[k] !== 4'(k + 1) || at[k] != 2 + 3 * k) begin
        errors++; $display("FAIL rr_order slot=%0d got=%h@%0d exp=%h@%0d", k, got[k], at[k], 4'(k + 1), 2 + 3 * k);
      end
    end
    @(negedge clk);
    r0 = 4'($urandom); r3 = 4'($urandom);
    req_valid = 4'b1001; rd[0] = r0; rd[3] = r3;
    @(negedge clk);
    req_valid = '0;
    n = 0;
    for (int c = 0; c < 16 && n < 2; c++) begin
      if (out_valid) begin got[n] = mux_out; gsel[n] = sel; n++; end
      if (n < 2) @(negedge clk);
    end
    checks++;
    if (n != 2 || gsel[0] !== 2'd0 || got[0] !== r0 || gsel[1] !== 2'd3 || got[1] !== r3) begin
      errors++;
      $display("FAIL rr_reload n=%0d got=ch%0d:%h,ch%0d:%h exp=ch0:%h,ch3:%h", n, gsel[0], got[0], gsel[1], got[1], r0, r3);
    end
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] r3;
    bit            seen;
    apply_reset();
    out_ready = 1'b0;
    req_valid = 4'b0010; rd[1] = 4'h5;
    @(negedge clk);
    req_valid = '0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (out_valid) seen = 1; else @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_wait_valid got=timeout exp=out_valid"); end
    r3 = 4'($urandom);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_valid !== 1'b1 || mux_out !== 4'h5 || req_ready[1] !== 1'b0) begin
        errors++; $display("FAIL bp_hold cyc=%0d out_valid=%b out=%h req_ready=%b exp 1/5/xx0x", i, out_valid, mux_out, req_ready);
      end
      if (i == 0) begin req_valid = 4'b1000; rd[3] = r3; end
      if (i == 1) begin
        checks++;
        if (req_ready[3] !== 1'b0) begin errors++; $display("FAIL bp_ch3_accept req_ready=%b exp=0xxx", req_ready); end
        req_valid = '0;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (out_valid) seen = 1; else @(negedge clk);
    end
    checks++;
    if (!seen || sel !== 2'd3 || mux_out !== r3) begin
      errors++; $display("FAIL bp_next seen=%0d sel=%0d out=%h exp 1/3/%h", seen, sel, mux_out, r3);
    end
  endtask

  task automatic test_full_channel;
    logic [DW-1:0] d [12];
    logic [DW-1:0] got [4];
    int            n;
    logic [DW-1:0] base;
    apply_reset();
    out_ready = 1'b1;
    base = 4'($urandom);
    for (int k = 0; k < 12; k++) d[k] = base + 4'(k);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid && n < 4) begin got[n] = mux_out; n++; end
      req_valid = 4'b0001; rd[0] = d[c];
      @(negedge clk);
    end
    req_valid = '0;
    checks++;
    if (n < 2 || got[0] !== d[0] || got[1] !== d[4]) begin
      errors++; $display("FAIL full_ignore n=%0d got=%h,%h exp=%h,%h", n, got[0], got[1], d[0], d[4]);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid_present;
    logic [DW-1:0] r0, r3;
    bit            seen;
    apply_reset();
    req_valid = 4'b0010; rd[1] = 4'($urandom);
    @(negedge clk);
    req_valid = '0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (out_valid) seen = 1; else @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_mid_wait got=timeout exp=out_valid"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sel !== 2'd0 || req_ready !== 4'b1111) begin
      errors++; $display("FAIL rst_mid_clear out_valid=%b sel=%0d req_ready=%b exp 0/0/1111", out_valid, sel, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet cyc=%0d out_valid=%b exp=0", i, out_valid); end
    end
    r0 = 4'($urandom); r3 = 4'($urandom);
    req_valid = 4'b1001; rd[0] = r0; rd[3] = r3;
    @(negedge clk);
    req_valid = '0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (out_valid) seen = 1; else @(negedge clk);
    end
    checks++;
    if (!seen || sel !== 2'd0 || mux_out !== r0) begin
      errors++; $display("FAIL rst_mid_first seen=%0d sel=%0d out=%h exp 1/0/%h", seen, sel, mux_out, r0);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_random_traffic;
    bit exp_valid;
    apply_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      exp_valid = (m_cur >= 0 && m_age >= 1);
      checks++;
      if (out_valid !== exp_valid) begin
        errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_valid);
      end
      checks++;
      if (sel !== m_sel) begin errors++; $display("FAIL rnd_sel cyc=%0d got=%0d exp=%0d", cyc, sel, m_sel); end
      checks++;
      if (req_ready !== ~m_full) begin
        errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, ~m_full);
      end
      if (exp_valid) begin
        checks++;
        if (mux_out !== m_data[m_cur]) begin
          errors++; $display("FAIL rnd_data cyc=%0d ch=%0d got=%h exp=%h", cyc, m_cur, mux_out, m_data[m_cur]);
        end
      end
      req_valid = 4'($urandom) & 4'($urandom | $urandom);
      for (int i = 0; i < 4; i++) rd[i] = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rd[i] = '0;
    test_reset();
    test_single_word();
    test_round_robin();
    test_backpressure();
    test_full_channel();
    test_reset_mid_present();
    test_random_traffic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
